vtx_accum_rmw: RTL
==================

VTX_ACCUM_RMW -- requirements
Module: vtx_accum_rmw

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning accumulator word width.
REQ-002 SHALL have parameter ADDR_RANGE, default 4096, meaning number of vertex entries.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, meaning URAM address width.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_accum  input  1  one-cycle pulse: IDLE→ACCUM.
REQ-007 SHALL have port cmd_drain  input  1  one-cycle pulse: end accumulation, read out all entries.
REQ-008 SHALL have port clr_on_drain  input  1  sampled with cmd_drain; 1 = zero each entry after readout.
REQ-009 SHALL have port in_valid / in_ready / in_addr / in_data  in/out/in/in  1/1/ADDR_WIDTH/DATA_WIDTH  update stream.
REQ-010 SHALL have port out_valid / out_ready / out_addr / out_data  out/in/out/out  1/1/ADDR_WIDTH/DATA_WIDTH  drain stream.
REQ-011 SHALL have port done  output  1  one-cycle pulse when drain completes.
REQ-012 SHALL have port ovf  output  1  sticky: some update saturated; cleared by cmd_accum.
REQ-013 SHALL have ports ce0, we0, addr0, wdata0, rdata0  (out, out, out, out, in)  (1, 1, ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH)  URAM port 0, used for reads only (we0 tied 0).
REQ-014 SHALL have ports ce1, we1, addr1, wdata1, rdata1  (out, out, out, out, in)  (1, 1, ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH)  URAM port 1, used for writes only (rdata1 unused).

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, FLUSH, DRAIN: IDLE→ACCUM on cmd_accum; ACCUM→FLUSH on cmd_drain; FLUSH→DRAIN when the RMW pipeline is empty; DRAIN→IDLE after the last entry is handed out; cmd_* SHALL be ignored in any other state.
REQ-016 SHALL drive in_ready=1 only in ACCUM; a handshake SHALL occur every cycle with no stall.
REQ-017 SHALL, for an update accepted in cycle t, assert ce0 with addr0=in_addr in t, and in t+1 assert ce1&we1 with addr1=addr and wdata1=sat(old+in_data).
REQ-018 SHALL add unsigned with saturation to 2^DATA_WIDTH-1 and set ovf on saturation.
REQ-019 SHALL hold a one-deep bypass (addr, value) of the write issued in the previous cycle; old = bypass value when the bypass is valid and the addresses match, else rdata0; this covers back-to-back same-address updates.
REQ-020 SHALL, in DRAIN, read addresses 0..ADDR_RANGE-1 in order on port 0, one per cycle while credit allows, and emit each through a 2-entry output buffer; issue SHALL require (buffer count + reads in flight) < 2.
REQ-021 SHALL hold out_addr/out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, when clr_on_drain=1, write 0 on port 1 to each address in the cycle after its read returns.
REQ-023 SHALL pulse done in the cycle the ADDR_RANGE-th output handshake completes, then return to IDLE.
REQ-024 SHALL drive ce0/ce1/we1 to 0 whenever no operation is issued.

Reset
REQ-025 SHALL, on rst_n=0 (asynchronous), force state IDLE and set in_ready, out_valid, done, ovf, ce0, ce1, we1, bypass valid, buffer count and drain counters to 0.
REQ-026 SHALL, on reset mid-ACCUM or mid-DRAIN, abandon in-flight operations with no further URAM write; memory contents are undefined afterwards.

Structure
REQ-027 SHALL place the FSM state encodings and the saturation-add width rule in shared package gfx_pkg.
REQ-028 SHALL implement the 2-entry drain output buffer as sub-module skid_fifo2.

Verification
REQ-029 SHALL cover: memory at 0; cmd_accum; updates (5,10),(5,7),(5,3) on consecutive cycles; drain → addr 5 outputs 20 (bypass path).
REQ-030 SHALL cover: (9,1), idle cycle, (9,2) → drain returns 3 at addr 9 (memory path, no bypass).
REQ-031 SHALL cover: entry 2 = 2^64-2 (DATA_WIDTH=64); update (2,5) → entry 2 = 2^64-1; ovf=1 until the next cmd_accum.
REQ-032 SHALL cover: ADDR_RANGE=8; drain with out_ready toggling 1,0,0,1…; outputs addr 0..7 in order, none lost or duplicated; done pulses once.
REQ-033 SHALL cover: drain with clr_on_drain=1, then a second drain → all 8 outputs = 0.
REQ-034 SHALL cover: rst_n low during DRAIN at addr 3 → out_valid=0 and ce1=0 immediately; state IDLE; cmd_drain in IDLE ignored.

Source files
------------

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared FSM encodings and saturating-add width rule for the graphics accumulators.
package gfx_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FLUSH, ST_DRAIN} state_t;
    // extra carry bits kept above the word; any set bit means the sum saturates
    localparam int SAT_GUARD = 1;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry FIFO; caller guarantees push only when space is available.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         valid,
    output logic [W-1:0] dout
);
    logic [W-1:0] mem [2];
    logic wp, rp;
    assign valid = count != 2'd0;
    assign dout = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
endmodule

// File: rtl/vtx_accum_rmw.sv
// vtx_accum_rmw: per-vertex saturating accumulator over a URAM (port 0 reads, port 1 writes)
// with a read-modify-write pipeline, one-deep write bypass and a credit-limited drain.
module vtx_accum_rmw
    import gfx_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_RANGE = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_accum,
    input  logic                  cmd_drain,
    input  logic                  clr_on_drain,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  done,
    output logic                  ovf,
    output logic                  ce0,
    output logic                  we0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] rdata0,
    output logic                  ce1,
    output logic                  we1,
    output logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] wdata1,
    input  logic [DATA_WIDTH-1:0] rdata1
);
    localparam logic [ADDR_WIDTH:0] RANGE = (ADDR_WIDTH+1)'(ADDR_RANGE);

    state_t state, state_n;
    logic p_valid, byp_valid, r_valid, clr_q;
    logic [ADDR_WIDTH-1:0] p_addr, byp_addr, r_addr;
    logic [DATA_WIDTH-1:0] p_data, byp_data, old, sat;
    logic [DATA_WIDTH+SAT_GUARD-1:0] sum;
    logic [ADDR_WIDTH:0] rd_cnt, out_cnt;
    logic [1:0] buf_cnt;
    logic accept, issue, pop, last_out, carry;
    logic unused_rdata1;

    assign unused_rdata1 = ^rdata1;
    assign in_ready = state == ST_ACCUM;
    assign accept = in_valid && in_ready;
    // a drain read may only issue if its result is guaranteed a buffer slot
    assign issue = state == ST_DRAIN && rd_cnt < RANGE && ({1'b0, buf_cnt} + {2'b0, r_valid}) < 3'd2;
    assign pop = out_valid && out_ready;
    assign last_out = pop && out_cnt == RANGE - 1'b1;
    assign done = state == ST_DRAIN && last_out;

    assign old = byp_valid && byp_addr == p_addr ? byp_data : rdata0;
    assign sum = {SAT_GUARD'(0), old} + {SAT_GUARD'(0), p_data};
    assign carry = |sum[DATA_WIDTH+SAT_GUARD-1:DATA_WIDTH];
    assign sat = carry ? '1 : sum[DATA_WIDTH-1:0];

    assign ce0 = accept || issue;
    assign we0 = 1'b0;
    assign wdata0 = '0;
    assign addr0 = issue ? rd_cnt[ADDR_WIDTH-1:0] : in_addr;
    assign ce1 = p_valid || (r_valid && clr_q);
    assign we1 = ce1;
    assign addr1 = p_valid ? p_addr : r_addr;
    assign wdata1 = p_valid ? sat : '0;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  state_n = cmd_accum ? ST_ACCUM : ST_IDLE;
            ST_ACCUM: state_n = cmd_drain ? ST_FLUSH : ST_ACCUM;
            ST_FLUSH: state_n = p_valid ? ST_FLUSH : ST_DRAIN;
            ST_DRAIN: state_n = last_out ? ST_IDLE : ST_DRAIN;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_addr <= '0;
            p_data <= '0;
            byp_valid <= 1'b0;
            byp_addr <= '0;
            byp_data <= '0;
            r_valid <= 1'b0;
            r_addr <= '0;
            clr_q <= 1'b0;
            rd_cnt <= '0;
            out_cnt <= '0;
            ovf <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_addr <= in_addr;
                p_data <= in_data;
            end
            byp_valid <= p_valid;
            if (p_valid) begin
                byp_addr <= p_addr;
                byp_data <= sat;
            end
            r_valid <= issue;
            if (issue) r_addr <= rd_cnt[ADDR_WIDTH-1:0];
            if (state == ST_IDLE && cmd_accum) ovf <= 1'b0;
            else if (p_valid && carry) ovf <= 1'b1;
            if (state == ST_ACCUM && cmd_drain) begin
                clr_q <= clr_on_drain;
                rd_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (issue) rd_cnt <= rd_cnt + 1'b1;
                if (pop) out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    skid_fifo2 #(.W(ADDR_WIDTH + DATA_WIDTH)) u_obuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_valid),
        .din   ({r_addr, rdata0}),
        .pop   (pop),
        .count (buf_cnt),
        .valid (out_valid),
        .dout  ({out_addr, out_data})
    );
endmodule
